fire_sequencer: RTL

Controller that sequences the shot counter and 7-segment display path. It debounces the raw trigger and reload buttons and enforces arming, single/burst mode, inter-shot gap, cooldown, magazine capacity and reload. It drives the counter's enable, fire and error inputs, so the counter only ever sees clean, rate-limited, one-cycle fire pulses.

---
 rtl/fire_sequencer.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/fire_sequencer.sv
`default_nettype none
// ============================================================================
// fire_sequencer : debounced trigger/reload sequencer for the shot counter
// Revision: 1.0
// ============================================================================

module fire_sequencer_debounce #(
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int CNT_W           = 27
) (
   input  logic clk,
   input  logic reset,
   input  logic sync_i,
   output logic press_o
);
   localparam logic [CNT_W-1:0] C_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [CNT_W-1:0] cnt_q;
   logic             level_q;
   logic             press_q;

   // press_q pulses in the same cycle the accepted level rises
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q   <= '0;
         level_q <= 1'b0;
         press_q <= 1'b0;
      end else begin
         press_q <= 1'b0;
         if (sync_i == level_q) begin
            cnt_q <= '0;
         end else if (cnt_q == C_LAST) begin
            cnt_q   <= '0;
            level_q <= sync_i;
            press_q <= sync_i;
         end else begin
            cnt_q <= cnt_q + 1'b1;
         end
      end
   end

   assign press_o = press_q;
endmodule

module fire_sequencer #(
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int BURST_GAP       = 10000000,
   parameter int COOLDOWN_CYCLES = 25000000,
   parameter int RELOAD_CYCLES   = 100000000,
   parameter int MAG_SIZE        = 6,
   parameter int BURST_LEN       = 3,
   parameter int CNT_W           = 27
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       arm,
   input  logic       trig_raw,
   input  logic       reload_raw,
   input  logic       mode_burst,
   output logic       enable,
   output logic       fire,
   output logic       error,
   output logic [3:0] rounds_left,
   output logic [2:0] state
);
   typedef enum logic [2:0] {
      S_DISARMED = 3'd0,
      S_READY    = 3'd1,
      S_FIRING   = 3'd2,
      S_GAP      = 3'd3,
      S_COOLDOWN = 3'd4,
      S_EMPTY    = 3'd5,
      S_RELOAD   = 3'd6
   } state_t;

   localparam logic [CNT_W-1:0] C_GAP_LAST    = CNT_W'(BURST_GAP - 2);
   localparam logic [CNT_W-1:0] C_COOL_LAST   = CNT_W'(COOLDOWN_CYCLES - 1);
   localparam logic [CNT_W-1:0] C_RELOAD_LAST = CNT_W'(RELOAD_CYCLES - 1);
   localparam logic [3:0]       C_MAG         = 4'(MAG_SIZE);
   localparam logic [3:0]       C_BLEN        = 4'(BURST_LEN);

   logic [1:0] arm_sync_q, trig_sync_q, reload_sync_q;
   logic       trig_press, reload_press;

   always_ff @(posedge clk) begin
      if (reset) begin
         arm_sync_q    <= '0;
         trig_sync_q   <= '0;
         reload_sync_q <= '0;
      end else begin
         arm_sync_q    <= {arm_sync_q[0], arm};
         trig_sync_q   <= {trig_sync_q[0], trig_raw};
         reload_sync_q <= {reload_sync_q[0], reload_raw};
      end
   end

   fire_sequencer_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_trig_db (
      .clk(clk), .reset(reset), .sync_i(trig_sync_q[1]), .press_o(trig_press)
   );

   fire_sequencer_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_reload_db (
      .clk(clk), .reset(reset), .sync_i(reload_sync_q[1]), .press_o(reload_press)
   );

   state_t           state_q, state_d;
   logic [3:0]       rounds_q, rounds_d;
   logic [3:0]       shots_q, shots_d;
   logic [CNT_W-1:0] timer_q, timer_d;
   logic             enable_q, fire_q, error_q;
   logic [3:0]       burst_shots;

   assign burst_shots = (rounds_q < C_BLEN) ? rounds_q : C_BLEN;

   // rounds/shots are decremented on entry to FIRING so they change with the pulse
   always_comb begin
      state_d  = state_q;
      rounds_d = rounds_q;
      shots_d  = shots_q;
      timer_d  = timer_q;
      if ((state_q != S_DISARMED) && !arm_sync_q[1]) begin
         state_d = S_DISARMED;
      end else begin
         case (state_q)
            S_DISARMED: begin
               if (arm_sync_q[1]) state_d = S_READY;
            end
            S_READY: begin
               if (trig_press) begin
                  if (rounds_q == 4'd0) begin
                     state_d = S_EMPTY;
                  end else begin
                     state_d  = S_FIRING;
                     rounds_d = rounds_q - 4'd1;
                     shots_d  = (mode_burst ? burst_shots : 4'd1) - 4'd1;
                  end
               end else if (reload_press && (rounds_q < C_MAG)) begin
                  state_d = S_RELOAD;
                  timer_d = '0;
               end
            end
            S_FIRING: begin
               timer_d = '0;
               state_d = (shots_q == 4'd0) ? S_COOLDOWN : S_GAP;
            end
            S_GAP: begin
               if (timer_q == C_GAP_LAST) begin
                  state_d  = S_FIRING;
                  rounds_d = rounds_q - 4'd1;
                  shots_d  = shots_q - 4'd1;
               end else begin
                  timer_d = timer_q + 1'b1;
               end
            end
            S_COOLDOWN: begin
               if (timer_q == C_COOL_LAST) state_d = S_READY;
               else                        timer_d = timer_q + 1'b1;
            end
            S_EMPTY: begin
               if (reload_press) begin
                  state_d = S_RELOAD;
                  timer_d = '0;
               end
            end
            S_RELOAD: begin
               if (timer_q == C_RELOAD_LAST) begin
                  state_d  = S_READY;
                  rounds_d = C_MAG;
               end else begin
                  timer_d = timer_q + 1'b1;
               end
            end
            default: state_d = S_DISARMED;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= S_DISARMED;
         rounds_q <= C_MAG;
         shots_q  <= '0;
         timer_q  <= '0;
         enable_q <= 1'b0;
         fire_q   <= 1'b0;
         error_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         rounds_q <= rounds_d;
         shots_q  <= shots_d;
         timer_q  <= timer_d;
         enable_q <= (state_d != S_DISARMED);
         fire_q   <= (state_d == S_FIRING);
         error_q  <= (state_d == S_EMPTY);
      end
   end

   assign enable      = enable_q;
   assign fire        = fire_q;
   assign error       = error_q;
   assign rounds_left = rounds_q;
   assign state       = state_q;
endmodule
`default_nettype wire
